// File: rtl/vector_addition_unit_pipelined_if.sv
// Operand/result bundle for the pipelined vector addition unit.
// The master drives the operand side and consumes results; the slave is the unit.
//   in_valid_i / in_ready_o    : operand handshake
//   vs2_i, vs1_i, vmask_i      : operands and per-element carry/borrow-in bits
//   vsew_i, vl_i               : element width code and active element count
//   reversed_i, add_sub_i,
//   compute_carry_i,
//   with_carry_borrow_i        : operation controls
//   out_valid_o / out_ready_i  : result handshake
//   vd_o                       : result vector
interface vector_addition_unit_pipelined_if #(
  parameter int unsigned VLEN = 128
);
  localparam int unsigned MASK_W = VLEN / 8;
  localparam int unsigned VL_W   = $clog2(VLEN / 8) + 1;

  logic              in_valid_i;
  logic              in_ready_o;
  logic [VLEN-1:0]   vs2_i;
  logic [VLEN-1:0]   vs1_i;
  logic [MASK_W-1:0] vmask_i;
  logic [1:0]        vsew_i;
  logic [VL_W-1:0]   vl_i;
  logic              reversed_i;
  logic              add_sub_i;
  logic              compute_carry_i;
  logic              with_carry_borrow_i;
  logic              out_valid_o;
  logic              out_ready_i;
  logic [VLEN-1:0]   vd_o;

  modport master (
    output in_valid_i, vs2_i, vs1_i, vmask_i, vsew_i, vl_i,
           reversed_i, add_sub_i, compute_carry_i, with_carry_borrow_i,
           out_ready_i,
    input  in_ready_o, out_valid_o, vd_o
  );

  modport slave (
    input  in_valid_i, vs2_i, vs1_i, vmask_i, vsew_i, vl_i,
           reversed_i, add_sub_i, compute_carry_i, with_carry_borrow_i,
           out_ready_i,
    output in_ready_o, out_valid_o, vd_o
  );
endinterface

// File: rtl/vector_addition_unit_pipelined.sv
// Two-stage pipelined vector add/sub unit with carry/borrow-in, carry/borrow-out
// mask generation, SEW 8/16/32/64 and vl tail zeroing.
//   clock_i   : rising-edge clock
//   reset_n_i : asynchronous active-low reset, discards everything in flight
//   bus       : operand/result bundle (slave side), see the interface file
// Stage 1 registers the accepted bundle; the arithmetic is evaluated from
// stage 1 and captured into stage 2, which drives vd_o / out_valid_o.
module vector_addition_unit_pipelined #(
  parameter int unsigned VLEN = 128
) (
  input  logic                               clock_i,
  input  logic                               reset_n_i,
  vector_addition_unit_pipelined_if.slave    bus
);
  localparam int unsigned MASK_W = VLEN / 8;
  localparam int unsigned VL_W   = $clog2(VLEN / 8) + 1;

  // Element operation on zero-extended lanes of width w (8..64).
  // Returns {carry_or_borrow, result}; the flag is bit w of the w+1-bit result.
  function automatic logic [64:0] elem_op(input logic [63:0] a,
                                          input logic [63:0] b,
                                          input logic        cin,
                                          input logic        sub,
                                          input logic        rev,
                                          input int unsigned w);
    logic [64:0] r;
    logic [64:0] r_sh;
    logic [63:0] lane_mask;
    // (1 << 64) wraps to 0, so the w=64 mask becomes all ones.
    lane_mask = (64'd1 << w) - 64'd1;
    if (sub && rev) begin
      r = {1'b0, b} - {1'b0, a};
    end else if (sub) begin
      r = {1'b0, a} - {1'b0, b} - {64'd0, cin};
    end else begin
      r = {1'b0, a} + {1'b0, b} + {64'd0, cin};
    end
    r_sh = r >> w;
    return {r_sh[0], r[63:0] & lane_mask};
  endfunction

  // Stage 1 state
  logic              s1_valid_q;
  logic [VLEN-1:0]   s1_vs2_q;
  logic [VLEN-1:0]   s1_vs1_q;
  logic [MASK_W-1:0] s1_vmask_q;
  logic [1:0]        s1_sew_q;
  logic [VL_W-1:0]   s1_vl_q;
  logic              s1_rev_q;
  logic              s1_sub_q;
  logic              s1_cc_q;
  logic              s1_wcb_q;

  // Stage 2 state
  logic              out_valid_q;
  logic [VLEN-1:0]   vd_q;
  logic [VLEN-1:0]   res_d;

  logic s2_load_s;
  logic in_ready_s;
  logic accept_s;

  assign s2_load_s  = !out_valid_q || bus.out_ready_i;
  assign in_ready_s = !s1_valid_q || s2_load_s;
  assign accept_s   = bus.in_valid_i && in_ready_s;

  assign bus.in_ready_o  = in_ready_s;
  assign bus.out_valid_o = out_valid_q;
  assign bus.vd_o        = vd_q;

  // Element-wise arithmetic on the stage-1 bundle.
  always_comb begin
    int unsigned w;
    int unsigned n;
    logic [63:0]       a;
    logic [63:0]       b;
    logic [64:0]       r;
    logic [MASK_W-1:0] msk_sh;
    logic              cin;
    logic              rev_eff;
    res_d   = '0;
    w       = 32'd8 << s1_sew_q;
    n       = VLEN >> (32'd3 + 32'(s1_sew_q));
    // Reverse only applies to the plain subtract form.
    rev_eff = s1_rev_q && s1_sub_q && !s1_cc_q && !s1_wcb_q;
    for (int unsigned i = 0; i < MASK_W; i++) begin
      a      = 64'(s1_vs2_q >> (i * w));
      b      = 64'(s1_vs1_q >> (i * w));
      a      = a & ((64'd1 << w) - 64'd1);
      b      = b & ((64'd1 << w) - 64'd1);
      msk_sh = s1_vmask_q >> i;
      cin    = s1_wcb_q && msk_sh[0];
      r      = elem_op(a, b, cin, s1_sub_q, rev_eff, w);
      // i < n bounds the lane count; i < vl also clamps vl > n to n.
      if ((i < n) && (i < 32'(s1_vl_q))) begin
        if (s1_cc_q) begin
          res_d = res_d | (VLEN'(r[64]) << i);
        end else begin
          res_d = res_d | (VLEN'(r[63:0]) << (i * w));
        end
      end else begin
        res_d = res_d;
      end
    end
  end

  // Stage 1: capture on accept, empty when its bundle moves on.
  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      s1_valid_q <= 1'b0;
      s1_vs2_q   <= '0;
      s1_vs1_q   <= '0;
      s1_vmask_q <= '0;
      s1_sew_q   <= 2'b00;
      s1_vl_q    <= '0;
      s1_rev_q   <= 1'b0;
      s1_sub_q   <= 1'b0;
      s1_cc_q    <= 1'b0;
      s1_wcb_q   <= 1'b0;
    end else if (accept_s) begin
      s1_valid_q <= 1'b1;
      s1_vs2_q   <= bus.vs2_i;
      s1_vs1_q   <= bus.vs1_i;
      s1_vmask_q <= bus.vmask_i;
      s1_sew_q   <= bus.vsew_i;
      s1_vl_q    <= bus.vl_i;
      s1_rev_q   <= bus.reversed_i;
      s1_sub_q   <= bus.add_sub_i;
      s1_cc_q    <= bus.compute_carry_i;
      s1_wcb_q   <= bus.with_carry_borrow_i;
    end else if (s2_load_s) begin
      s1_valid_q <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_q;
    end
  end

  // Stage 2: result register, held while the consumer stalls.
  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      out_valid_q <= 1'b0;
      vd_q        <= '0;
    end else if (s2_load_s) begin
      out_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        vd_q <= res_d;
      end else begin
        vd_q <= vd_q;
      end
    end else begin
      out_valid_q <= out_valid_q;
    end
  end
endmodule

// File: tb/tb_vector_addition_unit_pipelined.sv
// Directed bench for vector_addition_unit_pipelined (VLEN=128).
module tb_vector_addition_unit_pipelined;
  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  vector_addition_unit_pipelined_if #(.VLEN(128)) bus ();

  vector_addition_unit_pipelined #(.VLEN(128)) dut (
    .clock_i   (clk),
    .reset_n_i (rst_n),
    .bus       (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_in(input logic [1:0] sew, input logic [4:0] vl,
                        input logic [127:0] a, input logic [127:0] b,
                        input logic [15:0] m, input logic rev, input logic sub,
                        input logic cc, input logic wcb);
    bus.vsew_i              = sew;
    bus.vl_i                = vl;
    bus.vs2_i               = a;
    bus.vs1_i               = b;
    bus.vmask_i             = m;
    bus.reversed_i          = rev;
    bus.add_sub_i           = sub;
    bus.compute_carry_i     = cc;
    bus.with_carry_borrow_i = wcb;
  endtask

  // One bundle with no backpressure: result after 2 edges, valid for 1 cycle.
  task automatic run_one(input string tag, input logic [127:0] exp);
    bus.out_ready_i = 1'b1;
    bus.in_valid_i  = 1'b1;
    @(posedge clk); #1;
    bus.in_valid_i  = 1'b0;
    @(posedge clk); #1;
    check({tag, "_valid"}, 128'(bus.out_valid_o), 128'd1);
    check({tag, "_vd"}, bus.vd_o, exp);
    @(posedge clk); #1;
    check({tag, "_pulse"}, 128'(bus.out_valid_o), 128'd0);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    bus.in_valid_i  = 1'b0;
    bus.out_ready_i = 1'b1;
    set_in(2'b00, 5'd0, 128'd0, 128'd0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    #1;
    check("rst_in_ready", 128'(bus.in_ready_o), 128'd1);
    check("rst_out_valid", 128'(bus.out_valid_o), 128'd0);
    check("rst_vd", bus.vd_o, 128'd0);
    #11 rst_n = 1'b1;
    @(posedge clk); #1;

    // SEW8: every byte wraps to 0
    set_in(2'b00, 5'd16, {16{8'hFF}}, {16{8'h01}}, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    run_one("add8_wrap", 128'd0);
    // SEW8 distinct bytes
    set_in(2'b00, 5'd16, 128'h0F0E0D0C0B0A09080706050403020100, {16{8'h10}},
           16'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    run_one("add8_seq", 128'h1F1E1D1C1B1A19181716151413121110);
    // Same but vl=0
    set_in(2'b00, 5'd0, 128'h0F0E0D0C0B0A09080706050403020100, {16{8'h10}},
           16'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    run_one("vl_zero", 128'd0);
    // SEW32 carry-out mask
    set_in(2'b10, 5'd4, {4{32'hFFFFFFFF}}, 128'd1, 16'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    run_one("carry32", 128'h1);
    // SEW64 reverse sub with tail at vl=1
    set_in(2'b11, 5'd1, {64'd10, 64'd5}, {64'd3, 64'd7}, 16'd0, 1'b1, 1'b1, 1'b0, 1'b0);
    run_one("rsub64_tail", {64'd0, 64'd2});
    // SEW16 carry-in from mask
    set_in(2'b01, 5'd8, 128'd0, 128'd0, 16'h00AA, 1'b0, 1'b0, 1'b0, 1'b1);
    run_one("cin16", 128'h0001_0000_0001_0000_0001_0000_0001_0000);
    // SEW8 borrow-out with borrow-in everywhere
    set_in(2'b00, 5'd16, 128'd0, 128'd0, 16'hFFFF, 1'b0, 1'b1, 1'b1, 1'b1);
    run_one("borrow8", 128'h0000_FFFF);
    // SEW64 vl clamped from 16 to 2
    set_in(2'b11, 5'd16, {64'd1, 64'd2}, {64'd3, 64'd4}, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    run_one("vl_clamp", {64'd4, 64'd6});
    // SEW16 plain sub wraps
    set_in(2'b01, 5'd8, {8{16'h0005}}, {8{16'h0007}}, 16'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    run_one("sub16_wrap", {8{16'hFFFE}});
    // SEW32 reversed ignored when with_carry_borrow is set
    set_in(2'b10, 5'd4, {4{32'd10}}, {4{32'd3}}, 16'd0, 1'b1, 1'b1, 1'b0, 1'b1);
    run_one("rev_ignored", {4{32'd7}});
    // SEW16 borrow mask with tail at vl=3
    set_in(2'b01, 5'd3, 128'd0, {8{16'h0001}}, 16'd0, 1'b0, 1'b1, 1'b1, 1'b0);
    run_one("borrow16_tail", 128'h7);
    // SEW64 carry mask with carry-in on element 0 only
    set_in(2'b11, 5'd2, {128{1'b1}}, 128'd0, 16'h0001, 1'b0, 1'b0, 1'b1, 1'b1);
    run_one("carry64_cin", 128'h1);

    // Backpressure: four bundles, consumer stalled
    bus.out_ready_i = 1'b0;
    set_in(2'b00, 5'd16, {16{8'h11}}, 128'd0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    bus.in_valid_i = 1'b1;
    #1;
    check("bp_ready_a", 128'(bus.in_ready_o), 128'd1);
    @(posedge clk); #1;
    bus.vs2_i = {16{8'h22}};
    check("bp_ready_b", 128'(bus.in_ready_o), 128'd1);
    @(posedge clk); #1;
    bus.vs2_i = {16{8'h33}};
    check("bp_full_ready", 128'(bus.in_ready_o), 128'd0);
    check("bp_full_valid", 128'(bus.out_valid_o), 128'd1);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      check("bp_hold_ready", 128'(bus.in_ready_o), 128'd0);
      check("bp_hold_vd", bus.vd_o, {16{8'h11}});
      check("bp_hold_valid", 128'(bus.out_valid_o), 128'd1);
    end
    bus.out_ready_i = 1'b1;
    #1;
    check("bp_release_ready", 128'(bus.in_ready_o), 128'd1);
    @(posedge clk); #1;
    bus.vs2_i = {16{8'h44}};
    check("bp_out_b", bus.vd_o, {16{8'h22}});
    @(posedge clk); #1;
    bus.in_valid_i = 1'b0;
    check("bp_out_c", bus.vd_o, {16{8'h33}});
    @(posedge clk); #1;
    check("bp_out_d", bus.vd_o, {16{8'h44}});
    check("bp_out_d_valid", 128'(bus.out_valid_o), 128'd1);
    @(posedge clk); #1;
    check("bp_drained", 128'(bus.out_valid_o), 128'd0);

    // Reset mid-stream with both stages full
    bus.out_ready_i = 1'b0;
    set_in(2'b00, 5'd16, {16{8'h55}}, 128'd0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    bus.in_valid_i = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    bus.in_valid_i = 1'b0;
    check("rs_pre_valid", 128'(bus.out_valid_o), 128'd1);
    check("rs_pre_ready", 128'(bus.in_ready_o), 128'd0);
    #1 rst_n = 1'b0;
    #1;
    check("rs_out_valid", 128'(bus.out_valid_o), 128'd0);
    check("rs_in_ready", 128'(bus.in_ready_o), 128'd1);
    check("rs_vd", bus.vd_o, 128'd0);
    #4 rst_n = 1'b1;
    bus.out_ready_i = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      check("rs_no_spurious", 128'(bus.out_valid_o), 128'd0);
    end
    set_in(2'b01, 5'd8, {8{16'h1234}}, {8{16'h1111}}, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    run_one("post_reset", {8{16'h2345}});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
